// File: rtl/conv_12a8_pkg.sv
// rtl/conv_12a8_pkg.sv - shared gearbox width constants for the 12-to-8 converter
package conv_12a8_pkg;

  localparam int IN_W  = 12;
  localparam int OUT_W = 8;
  localparam int BUF_W = 24;
  localparam int CNT_W = 5;

endpackage

// File: rtl/conv_12a8_bit_reservoir.sv
// rtl/conv_12a8_bit_reservoir.sv - combinational pop-8 / push-12 bit reservoir update
module conv_12a8_bit_reservoir
  import conv_12a8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [BUF_W-1:0] buf_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             pop,
  input  logic             push,
  input  logic [IN_W-1:0]  word,
  output logic [BUF_W-1:0] buf_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [OUT_W-1:0] head_o
);

  localparam logic [CNT_W-1:0] IN_W_C  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);

  logic [BUF_W-1:0] buf_pop;
  logic [CNT_W-1:0] cnt_pop;
  logic [BUF_W-1:0] word_ext;

  // Oldest bits sit at the low end (LSB-first) or the high end (MSB-first);
  // the pop removes them first, then the new word lands right behind what is left.
  // Bits outside the valid window are always zero, which makes flush padding free.
  always_comb begin
    buf_pop  = buf_i;
    cnt_pop  = cnt_i;
    word_ext = {{(BUF_W-IN_W){1'b0}}, word};
    if (pop) begin
      buf_pop = MSB_FIRST ? (buf_i << OUT_W) : (buf_i >> OUT_W);
      cnt_pop = cnt_i - OUT_W_C;
    end
    buf_o = buf_pop;
    cnt_o = cnt_pop;
    if (push) begin
      if (MSB_FIRST) begin
        buf_o = buf_pop | (word_ext << (IN_W_C - cnt_pop));
      end else begin
        buf_o = buf_pop | (word_ext << cnt_pop);
      end
      cnt_o = cnt_pop + IN_W_C;
    end
    head_o = MSB_FIRST ? buf_o[BUF_W-1 -: OUT_W] : buf_o[OUT_W-1:0];
  end

endmodule

// File: rtl/conv_12a8.sv
// rtl/conv_12a8.sv - 12-bit to 8-bit width gearbox; optional flush via CONV12A8_FLUSH_EN
module conv_12a8
  import conv_12a8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef CONV12A8_FLUSH_EN
  ,
  input  logic              flush,
  output logic              flush_busy
`endif
);

  localparam logic [CNT_W-1:0] IN_W_C  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             s_ready_q, s_ready_d;
  logic             busy_d;

  logic             in_fire, out_fire;
  logic [BUF_W-1:0] res_buf;
  logic [CNT_W-1:0] res_cnt;
  logic [OUT_W-1:0] res_head;

  assign in_fire  = s_valid & s_ready_q;
  assign out_fire = m_valid_q & m_ready;

  conv_12a8_bit_reservoir #(
    .MSB_FIRST (MSB_FIRST)
  ) u_reservoir (
    .buf_i  (buf_q),
    .cnt_i  (cnt_q),
    .pop    (out_fire),
    .push   (in_fire),
    .word   (s_data),
    .buf_o  (res_buf),
    .cnt_o  (res_cnt),
    .head_o (res_head)
  );

`ifdef CONV12A8_FLUSH_EN
  logic flush_busy_q;
`endif

  // Next-state: reservoir update, flush padding, and registered handshake outputs.
  always_comb begin
    buf_d  = res_buf;
    cnt_d  = res_cnt;
    busy_d = 1'b0;
`ifdef CONV12A8_FLUSH_EN
    busy_d = flush_busy_q ? (cnt_q != '0) : flush;
    // Residue bits are already zero above the valid window, so padding is just a count bump.
    if (flush_busy_q && (cnt_q == CNT_W'(4))) begin
      cnt_d = OUT_W_C;
    end
`endif
    m_data_d  = res_head;
    m_valid_d = (cnt_d >= OUT_W_C);
    s_ready_d = (cnt_d <= IN_W_C) && !busy_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
    end
  end

`ifdef CONV12A8_FLUSH_EN
  // Flush-in-progress flag; holds off new input until the padded residue drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_busy_q <= 1'b0;
    end else begin
      flush_busy_q <= busy_d;
    end
  end

  assign flush_busy = flush_busy_q;
`endif

  assign s_ready = s_ready_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_conv_12a8.sv
// tb/tb_conv_12a8.sv - scoreboard bench for conv_12a8, both bit orders side by side
module tb_conv_12a8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] s_data;
  logic        s_valid;
  logic        m_ready;
  logic        flush;
  logic        s_ready_l, m_valid_l, s_ready_m, m_valid_m;
  logic [7:0]  m_data_l, m_data_m;
  logic        flush_busy_l, flush_busy_m;

  int compared   = 0;
  int mismatched = 0;

  bit         bq_l[$];
  bit         bq_m[$];
  logic [7:0] eq_l[$];
  logic [7:0] eq_m[$];
  logic [7:0] log_l[$];
  logic [7:0] log_m[$];
  logic [7:0] bl, bm;

  always #5 clk = ~clk;

  conv_12a8 #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_l),
    .m_data(m_data_l), .m_valid(m_valid_l), .m_ready(m_ready)
`ifdef CONV12A8_FLUSH_EN
    , .flush(flush), .flush_busy(flush_busy_l)
`endif
  );

  conv_12a8 #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_m),
    .m_data(m_data_m), .m_valid(m_valid_m), .m_ready(m_ready)
`ifdef CONV12A8_FLUSH_EN
    , .flush(flush), .flush_busy(flush_busy_m)
`endif
  );

`ifndef CONV12A8_FLUSH_EN
  assign flush_busy_l = 1'b0;
  assign flush_busy_m = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 40; k++) begin
      if (eq_l.size() == 0 && eq_m.size() == 0 && !m_valid_l && !m_valid_m) break;
      step();
    end
    if (k == 40) check({tag, "_drain_timeout"}, 0, 1);
  endtask

  task automatic clear_model();
    bq_l.delete(); bq_m.delete();
    eq_l.delete(); eq_m.delete();
    log_l.delete(); log_m.delete();
  endtask

  // Bit-stream reference model and output scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid_l && m_ready) begin
        log_l.push_back(m_data_l);
        if (eq_l.size() == 0) check("sb_l_underflow", 1, 0);
        else check("sb_l", m_data_l, eq_l.pop_front());
      end
      if (m_valid_m && m_ready) begin
        log_m.push_back(m_data_m);
        if (eq_m.size() == 0) check("sb_m_underflow", 1, 0);
        else check("sb_m", m_data_m, eq_m.pop_front());
      end
      if (s_valid && s_ready_l)
        for (int i = 0; i < 12; i++) bq_l.push_back(s_data[i]);
      if (s_valid && s_ready_m)
        for (int i = 11; i >= 0; i--) bq_m.push_back(s_data[i]);
`ifdef CONV12A8_FLUSH_EN
      if (flush && !flush_busy_l)
        while (bq_l.size() % 8 != 0) bq_l.push_back(1'b0);
      if (flush && !flush_busy_m)
        while (bq_m.size() % 8 != 0) bq_m.push_back(1'b0);
`endif
      while (bq_l.size() >= 8) begin
        for (int i = 0; i < 8; i++) bl[i] = bq_l.pop_front();
        eq_l.push_back(bl);
      end
      while (bq_m.size() >= 8) begin
        for (int i = 7; i >= 0; i--) bm[i] = bq_m.pop_front();
        eq_m.push_back(bm);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps, timeouts, k;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; flush = 1'b0;
    step(); step(); step();

    // reset state
    check("rst_m_valid_l", m_valid_l, 0);
    check("rst_m_valid_m", m_valid_m, 0);
    check("rst_s_ready_l", s_ready_l, 1);
    check("rst_m_data_l", m_data_l, 8'h00);
    check("rst_flush_busy_l", flush_busy_l, 0);
    rst_n = 1'b1;
    step();

    // 1/2: two words, both orderings
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 12'hABC;
    step();
    check("t1_latency_valid", m_valid_l, 1);
    s_data = 12'hDEF;
    step();
    s_valid = 1'b0;
    drain("t1");
    check_bytes("t1_lsb", log_l, '{8'hBC, 8'hFA, 8'hDE});
    check_bytes("t2_msb", log_m, '{8'hAB, 8'hCD, 8'hEF});
    check("t1_idle_s_ready", s_ready_l, 1);
    clear_model();

    // 3: backpressure
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 12'h123;
    step();
    check("t3_s_ready_after1", s_ready_l, 1);
    s_data = 12'h456;
    step();
    s_data = 12'h789;
    for (int i = 0; i < 4; i++) begin
      check("t3_s_ready_full", s_ready_l, 0);
      check("t3_hold_l", m_data_l, 8'h23);
      check("t3_hold_m", m_data_m, 8'h12);
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    drain("t3");
    check_bytes("t3_lsb", log_l, '{8'h23, 8'h61, 8'h45});
    check_bytes("t3_msb", log_m, '{8'h12, 8'h34, 8'h56});
    clear_model();

    // 4: streaming, 200 random words
    gaps = 0; timeouts = 0;
    m_ready = 1'b1;
    for (int w = 0; w < 200; w++) begin
      s_data = 12'($urandom);
      s_valid = 1'b1;
      k = 0;
      while (!s_ready_l && k < 10) begin
        step(); k++;
        if (!m_valid_l) gaps++;
      end
      if (k == 10) timeouts++;
      step();
      if (!m_valid_l) gaps++;
    end
    s_valid = 1'b0;
    drain("t4");
    check("t4_timeouts", timeouts, 0);
    check("t4_valid_gaps", gaps, 0);
    check("t4_bytes_l", log_l.size(), 300);
    check("t4_bytes_m", log_m.size(), 300);
    clear_model();

    // 5: reset mid-stream at 20 bits
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 12'hAAA;
    step();
    s_data = 12'h555;
    step();
    s_valid = 1'b0; m_ready = 1'b1;
    step(); step();
    m_ready = 1'b0; s_valid = 1'b1; s_data = 12'hF0F;
    step();
    s_valid = 1'b0;
    check("t5_s_ready_at20", s_ready_l, 0);
    #1;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("t5_async_m_valid_l", m_valid_l, 0);
    check("t5_async_m_valid_m", m_valid_m, 0);
    check("t5_async_s_ready_l", s_ready_l, 1);
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 12'h123;
    step();
    s_valid = 1'b0;
    drain("t5a");
    for (int i = 0; i < 5; i++) step();
    check("t5_residue_wait", m_valid_l, 0);
    s_valid = 1'b1; s_data = 12'h456;
    step();
    s_valid = 1'b0;
    drain("t5b");
    check_bytes("t5_lsb", log_l, '{8'h23, 8'h61, 8'h45});
    check_bytes("t5_msb", log_m, '{8'h12, 8'h34, 8'h56});
    clear_model();

`ifdef CONV12A8_FLUSH_EN
    // 6: flush of a 4-bit residue, then flush with empty reservoir
    s_valid = 1'b1; s_data = 12'h5A7;
    step();
    s_valid = 1'b0;
    drain("t6a");
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_busy_set", flush_busy_l, 1);
    k = 0;
    while (flush_busy_l && k < 20) begin
      check("t6_s_ready_busy", s_ready_l, 0);
      step(); k++;
    end
    if (k == 20) check("t6_busy_timeout", 0, 1);
    check("t6_s_ready_after", s_ready_l, 1);
    drain("t6b");
    check_bytes("t6_lsb", log_l, '{8'hA7, 8'h05});
    check_bytes("t6_msb", log_m, '{8'h5A, 8'h70});
    clear_model();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_empty_busy", flush_busy_l, 1);
    step();
    check("t6_empty_clear", flush_busy_l, 0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
